// File: rtl/serial_crc_checker.sv
// Bit-serial CRC checker: shifts a {message, crc} codeword MSB-first through an LFSR
// and reports the remainder of codeword(x)*x^CRC_W mod G(x) together with the message.
module serial_crc_checker #(
  parameter int                 MSG_W = 10,
  parameter int                 CRC_W = 3,
  parameter logic [CRC_W-1:0]   POLY  = 3'b011,
  localparam int                CW_W  = MSG_W + CRC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CW_W-1:0]   codeword_in,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic [CRC_W-1:0]  syndrome,
  output logic [MSG_W-1:0]  msg_out,
  output logic [7:0]        err_cnt
);

  localparam int CNT_W = $clog2(CW_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CW_W-1:0]    sr;
  logic [CRC_W-1:0]   lfsr;
  logic [CRC_W-1:0]   lfsr_step;
  logic [CNT_W-1:0]   cnt;
  logic [MSG_W-1:0]   msg_lat;
  logic               fb;
  logic               last_shift;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fb         = lfsr[CRC_W-1] ^ sr[CW_W-1];
  assign lfsr_step  = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign last_shift = (cnt == CNT_W'(CW_W - 1));

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Results are captured on the edge that enters DONE so they are valid while done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr       <= '0;
      lfsr     <= '0;
      cnt      <= '0;
      msg_lat  <= '0;
      crc_ok   <= 1'b0;
      syndrome <= '0;
      msg_out  <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= codeword_in;
            msg_lat <= codeword_in[CW_W-1:CRC_W];
            lfsr    <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          sr   <= {sr[CW_W-2:0], 1'b0};
          lfsr <= lfsr_step;
          cnt  <= cnt + CNT_W'(1);
          if (last_shift) begin
            syndrome <= lfsr_step;
            crc_ok   <= (lfsr_step == '0);
            msg_out  <= msg_lat;
            if (lfsr_step != '0) err_cnt <= sat_inc(err_cnt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_crc_checker.sv
// Directed bench for serial_crc_checker: vector table plus back-to-back, mid-check reset
// and error-counter saturation sequences.
module tb_serial_crc_checker;

  localparam int MSG_W = 10;
  localparam int CRC_W = 3;
  localparam int CW_W  = MSG_W + CRC_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CW_W-1:0]   codeword_in;
  logic              busy;
  logic              done;
  logic              crc_ok;
  logic [CRC_W-1:0]  syndrome;
  logic [MSG_W-1:0]  msg_out;
  logic [7:0]        err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_err = 0;

  serial_crc_checker dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .codeword_in (codeword_in),
    .busy        (busy),
    .done        (done),
    .crc_ok      (crc_ok),
    .syndrome    (syndrome),
    .msg_out     (msg_out),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW_W-1:0]  cw;
    logic             ok;
    logic [CRC_W-1:0] syn;
    logic [MSG_W-1:0] msg;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_crc_ok"},   32'(crc_ok),   32'd0);
    check({tag, "_syndrome"}, 32'(syndrome), 32'd0);
    check({tag, "_msg_out"},  32'(msg_out),  32'd0);
    check({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
  endtask

  // One full check: pulse start, wait (bounded) for done, verify latency and results.
  task automatic run_check(input string name, input logic [CW_W-1:0] cw, input logic ok,
                           input logic [CRC_W-1:0] syn, input logic [MSG_W-1:0] msg);
    int  lat;
    bit  seen;
    @(negedge clk);
    start       = 1'b1;
    codeword_in = cw;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    codeword_in = '0;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    lat  = 1;
    seen = 1'b0;
    while (lat <= 30) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      if (!ok && exp_err < 255) exp_err++;
      check({name, "_latency"},  32'(lat),      32'd14);
      check({name, "_busy"},     32'(busy),     32'd1);
      check({name, "_crc_ok"},   32'(crc_ok),   32'(ok));
      check({name, "_syndrome"}, 32'(syndrome), 32'(syn));
      check({name, "_msg_out"},  32'(msg_out),  32'(msg));
      check({name, "_err_cnt"},  32'(err_cnt),  32'(exp_err));
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(done),     32'd0);
      check({name, "_idle_busy"},      32'(busy),     32'd0);
      check({name, "_syndrome_held"},  32'(syndrome), 32'(syn));
      check({name, "_msg_held"},       32'(msg_out),  32'(msg));
    end
  endtask

  initial begin
    vecs[0] = '{cw: 13'b1100000011100, ok: 1'b1, syn: 3'b000, msg: 10'b1100000011};
    vecs[1] = '{cw: 13'b1011001011000, ok: 1'b1, syn: 3'b000, msg: 10'b1011001011};
    vecs[2] = '{cw: 13'b1100000011101, ok: 1'b0, syn: 3'b011, msg: 10'b1100000011};
    vecs[3] = '{cw: 13'b1100000011110, ok: 1'b0, syn: 3'b110, msg: 10'b1100000011};
    vecs[4] = '{cw: 13'b0100000011100, ok: 1'b0, syn: 3'b010, msg: 10'b0100000011};
    vecs[5] = '{cw: 13'b0000000000000, ok: 1'b1, syn: 3'b000, msg: 10'b0000000000};

    reset       = 1'b0;
    start       = 1'b0;
    codeword_in = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].cw, vecs[i].ok, vecs[i].syn, vecs[i].msg);
    end

    // Start held high: re-accepted every CW_W+2 cycles, start ignored while busy.
    begin
      int n_done;
      logic exp_done;
      logic exp_busy;
      n_done = 0;
      @(negedge clk);
      start       = 1'b1;
      codeword_in = vecs[0].cw;
      @(posedge clk);
      for (int i = 1; i <= 50; i++) begin
        @(negedge clk);
        if (i == 40) start = 1'b0;
        exp_done = (i == 14 || i == 29 || i == 44);
        exp_busy = !(i == 15 || i == 30 || i >= 45);
        check($sformatf("b2b_done_c%0d", i), 32'(done), 32'(exp_done));
        check($sformatf("b2b_busy_c%0d", i), 32'(busy), 32'(exp_busy));
        if (done) begin
          n_done++;
          check($sformatf("b2b_crc_ok_c%0d", i), 32'(crc_ok), 32'd1);
        end
      end
      check("b2b_done_count", 32'(n_done), 32'd3);
      check("b2b_err_cnt", 32'(err_cnt), 32'(exp_err));
    end

    // Reset during SHIFT aborts the check with no done pulse.
    begin
      int n_done;
      n_done = 0;
      @(negedge clk);
      start       = 1'b1;
      codeword_in = vecs[2].cw;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check_outputs_zero("midrst");
      exp_err = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check("midrst_no_done", 32'(n_done), 32'd0);
      check("midrst_err_cnt", 32'(err_cnt), 32'd0);
      run_check("after_rst_good", vecs[0].cw, 1'b1, 3'b000, vecs[0].msg);
      run_check("after_rst_bad",  vecs[2].cw, 1'b0, 3'b011, vecs[2].msg);
    end

    for (int i = 0; i < 260; i++) begin
      run_check($sformatf("sat%0d", i), vecs[3].cw, 1'b0, 3'b110, vecs[3].msg);
    end
    check("sat_final_err_cnt", 32'(err_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_crc_checker.md
SERIAL_CRC_CHECKER -- requirements
Module: serial_crc_checker

Interface
REQ-001 Parameter MSG_W, default 10, message width in bits.
REQ-002 Parameter CRC_W, default 3, CRC width in bits.
REQ-003 Parameter POLY, default 3'b011, low CRC_W coefficients of G(x) with implicit leading 1 (default G = x^3+x+1).
REQ-004 Local constant CW_W = MSG_W+CRC_W (default 13), codeword width.
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low; 0 SHALL clear all state immediately.
REQ-007 start  input  1  request to check the codeword on codeword_in.
REQ-008 codeword_in  input  CW_W  {message, crc}, MSB first; sampled only on an accepted start.
REQ-009 busy  output  1  high while a check is in progress.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 crc_ok  output  1  1 = syndrome zero; held until the next done.
REQ-012 syndrome  output  CRC_W  remainder of codeword(x)*x^CRC_W mod G(x); held until the next done.
REQ-013 msg_out  output  MSG_W  message field of the last checked codeword; held until the next done.
REQ-014 err_cnt  output  8  count of failed checks, saturating.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 IDLE with start=1 SHALL load shift register <= codeword_in, lfsr <= 0 and bit counter <= 0, then go to SHIFT.
REQ-017 start SHALL be ignored in SHIFT and DONE; there is no queuing.
REQ-018 Each SHIFT cycle SHALL compute fb = lfsr[CRC_W-1] ^ sr[CW_W-1], then lfsr <= {lfsr[CRC_W-2:0],0} ^ (fb ? POLY : 0).
REQ-019 Each SHIFT cycle SHALL also shift sr left by 1 and increment the counter.
REQ-020 SHIFT SHALL last exactly CW_W cycles; on the cycle the counter equals CW_W-1, the next state SHALL be DONE.
REQ-021 The counter SHALL be ceil(log2(CW_W)) bits wide and SHALL NOT wrap within a check.
REQ-022 DONE SHALL last one cycle with done=1, and SHALL register syndrome <= lfsr, crc_ok <= (lfsr==0) and msg_out <= latched message bits.
REQ-023 DONE SHALL go to IDLE on the next cycle.
REQ-024 Latency: an accepted start at edge N SHALL give done=1 during the cycle after edge N+CW_W (14 cycles at default).
REQ-025 Back-to-back period SHALL be CW_W+2 cycles per codeword; a start held high SHALL be re-accepted in the IDLE that follows DONE.
REQ-026 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-027 In DONE, if lfsr != 0 and err_cnt < 255, err_cnt SHALL increment by 1.
REQ-028 At 255, err_cnt SHALL hold; it SHALL be cleared only by reset.
REQ-029 Outputs crc_ok, syndrome and msg_out SHALL change only in DONE (or on reset).

Reset
REQ-030 reset=0 SHALL force state IDLE, and SHALL force busy=0, done=0, crc_ok=0, syndrome=0, msg_out=0, err_cnt=0, with lfsr, sr and counter also 0.
REQ-031 reset asserted mid-SHIFT SHALL abort the check with no done pulse and no err_cnt change.
REQ-032 After reset deassertion, the first start SHALL be accepted on the first rising edge at which start=1.

Verification
REQ-033 Good codeword: codeword_in=13'b1100000011100, start pulse -> done after 14 cycles, crc_ok=1, syndrome=3'b000, msg_out=10'b1100000011, err_cnt=0.
REQ-034 Second good codeword: codeword_in=13'b1011001011000 -> crc_ok=1, syndrome=3'b000, msg_out=10'b1011001011.
REQ-035 Single-bit error: codeword_in=13'b1100000011101 (LSB flipped) -> crc_ok=0, syndrome=3'b011, err_cnt=1.
REQ-036 Ignored start and back-to-back: start held high for 40 cycles with a good codeword -> done pulses exactly every 15 cycles, busy low for exactly 1 cycle between checks, no extra dones.
REQ-037 Reset mid-operation: reset=0 at SHIFT cycle 6 -> all outputs 0 immediately, no done; a new check after release gives correct results.
REQ-038 Saturation: 260 consecutive bad codewords -> err_cnt stops at 255 and crc_ok=0 on each done.
